// File: rtl/q8_12_pkg.sv
// Shared Q8.12 definitions used by the divider and the BCD converter.
// Holds the default field widths, the converter state encoding and the quotient word type.
package q8_12_pkg;

  localparam int INT_BITS    = 8;
  localparam int FRAC_BITS   = 12;
  localparam int INT_DIGITS  = 3;
  localparam int FRAC_DIGITS = 4;

  typedef logic [INT_BITS+FRAC_BITS-1:0] q8_12_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INT  = 2'd1,
    FRAC = 2'd2,
    DONE = 2'd3
  } conv_state_t;

endpackage

// File: rtl/converter_q8_12_bcd_passo_frac.sv
// One fractional-digit step: multiplies the remainder by ten and splits the result
// into the next decimal digit and the new remainder.
module passo_frac #(
  parameter int FRAC_BITS = q8_12_pkg::FRAC_BITS
) (
  input  logic [FRAC_BITS-1:0] frac_r,
  output logic [3:0]           digit,
  output logic [FRAC_BITS-1:0] frac_next
);

  logic [FRAC_BITS+3:0] p;

  // x*10 as x*8 + x*2, widened first so the carry into the digit field is kept
  assign p         = ({4'b0000, frac_r} << 3) + ({4'b0000, frac_r} << 1);
  assign digit     = p[FRAC_BITS+3:FRAC_BITS];
  assign frac_next = p[FRAC_BITS-1:0];

endmodule

// File: rtl/converter_q8_12_bcd.sv
// Serial Q8.12 to packed BCD converter: double-dabble for the integer part,
// repeated multiply-by-ten for truncated fractional digits, valid/ready on both sides.
module converter_q8_12_bcd
  import q8_12_pkg::*;
#(
  parameter int INT_BITS    = q8_12_pkg::INT_BITS,
  parameter int FRAC_BITS   = q8_12_pkg::FRAC_BITS,
  parameter int INT_DIGITS  = q8_12_pkg::INT_DIGITS,
  parameter int FRAC_DIGITS = q8_12_pkg::FRAC_DIGITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INT_BITS+FRAC_BITS-1:0] valor,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [4*INT_DIGITS-1:0]       bcd_int,
  output logic [4*FRAC_DIGITS-1:0]      bcd_frac
);

  localparam int ACC_W  = 4 * INT_DIGITS;
  localparam int FACC_W = 4 * FRAC_DIGITS;
  localparam int CNT_MAX = (INT_BITS > FRAC_DIGITS) ? INT_BITS : FRAC_DIGITS;
  localparam int CNT_W  = $clog2(CNT_MAX + 1);

  conv_state_t            state;
  logic [CNT_W-1:0]       cnt;
  logic [INT_BITS-1:0]    int_sr;
  logic [FRAC_BITS-1:0]   frac_r;
  logic [ACC_W-1:0]       int_acc;
  logic [ACC_W-1:0]       int_adj;
  logic [FACC_W-1:0]      frac_acc;
  logic [3:0]             digit;
  logic [FRAC_BITS-1:0]   frac_next;

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
  // NOTE: blocking assignments are correct here: this is a combinational function
  // whose local copy is updated in place, digit by digit.
  function automatic logic [ACC_W-1:0] dabble_adj(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] res;
    res = acc;
    for (int d = 0; d < INT_DIGITS; d++) begin
      if (res[4*d +: 4] >= 4'd5) res[4*d +: 4] = res[4*d +: 4] + 4'd3;
    end
    return res;
  endfunction

  assign int_adj = dabble_adj(int_acc);

  passo_frac #(.FRAC_BITS(FRAC_BITS)) u_passo_frac (
    .frac_r    (frac_r),
    .digit     (digit),
    .frac_next (frac_next)
  );

  // NOTE: all state, including the registered handshake outputs, updates with
  // non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      int_sr    <= '0;
      frac_r    <= '0;
      int_acc   <= '0;
      frac_acc  <= '0;
      bcd_int   <= '0;
      bcd_frac  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            int_sr   <= valor[INT_BITS+FRAC_BITS-1:FRAC_BITS];
            frac_r   <= valor[FRAC_BITS-1:0];
            int_acc  <= '0;
            frac_acc <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= INT;
          end
        end
        INT: begin
          int_acc <= {int_adj[ACC_W-2:0], int_sr[INT_BITS-1]};
          int_sr  <= int_sr << 1;
          if (cnt == CNT_W'(INT_BITS - 1)) begin
            cnt   <= '0;
            state <= FRAC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FRAC: begin
          frac_r   <= frac_next;
          frac_acc <= {frac_acc[FACC_W-5:0], digit};
          if (cnt == CNT_W'(FRAC_DIGITS - 1)) begin
            // Visible result is refreshed only here, so it holds through any stall
            bcd_int   <= int_acc;
            bcd_frac  <= {frac_acc[FACC_W-5:0], digit};
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_converter_q8_12_bcd.sv
// Self-checking bench for converter_q8_12_bcd: directed corner values, backpressure,
// mid-conversion reset and a random stream scored against a decimal arithmetic model.
module tb_converter_q8_12_bcd;

  localparam int N_STREAM = 50;
  localparam int LATENCY  = 12;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] valor;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd_int;
  logic [15:0] bcd_frac;

  int n_checks = 0;
  int n_errors = 0;

  logic        mon_en = 1'b0;
  logic [27:0] exp_q[$];
  int          rx_count = 0;

  converter_q8_12_bcd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .valor     (valor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_int   (bcd_int),
    .bcd_frac  (bcd_frac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal reference: integer part and floor(frac * 10^4 / 4096), split into digits.
  function automatic logic [27:0] model(input logic [19:0] v);
    int ip, fp;
    logic [11:0] bi;
    logic [15:0] bf;
    ip = int'(v[19:12]);
    fp = (int'(v[11:0]) * 10000) / 4096;
    bi = {4'(ip / 100), 4'((ip / 10) % 10), 4'(ip % 10)};
    bf = {4'(fp / 1000), 4'((fp / 100) % 10), 4'((fp / 10) % 10), 4'(fp % 10)};
    return {bi, bf};
  endfunction

  task automatic wait_ready(input string tag);
    int g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Called #1 after the acceptance edge; waits for out_valid and checks latency and data.
  task automatic collect(input logic [19:0] v, input string tag);
    int lat = 0;
    logic [27:0] e;
    e = model(v);
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LATENCY));
    check({tag, "_int"}, 32'(bcd_int), 32'(e[27:16]));
    check({tag, "_frac"}, 32'(bcd_frac), 32'(e[15:0]));
  endtask

  task automatic convert(input logic [19:0] v, input string tag);
    out_ready = 1'b1;
    wait_ready(tag);
    valor    = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect(v, tag);
    @(posedge clk); #1;
    check({tag, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  // Stream scoreboard: handshakes are observed on the falling edge, before the edge that takes them.
  always @(negedge clk) begin
    if (mon_en) begin
      if (in_valid && in_ready) exp_q.push_back(model(valor));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected_out", 32'd1, 32'd0);
        end else begin
          logic [27:0] e;
          e = exp_q.pop_front();
          check("stream_data", {4'h0, bcd_int, bcd_frac}, {4'h0, e});
        end
        rx_count++;
      end
    end
  end

  initial begin
    logic [19:0] v1, v2;
    logic [27:0] hold;
    logic        stable;
    int          seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    valor     = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bcd", {4'h0, bcd_int, bcd_frac}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    convert(20'h0C492, "div86_7");
    convert(20'hFFFFF, "max");
    convert(20'h00000, "zero");
    convert(20'h01800, "one_half");
    convert(20'h00001, "lsb_trunc");

    // Backpressure: result held for 20 cycles while a new input is offered and refused
    v1 = 20'($urandom);
    v2 = 20'($urandom);
    out_ready = 1'b0;
    wait_ready("bp");
    valor    = v1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect(v1, "bp_first");
    hold     = {bcd_int, bcd_frac};
    valor    = v2;
    in_valid = 1'b1;
    stable   = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || ({bcd_int, bcd_frac} != hold)) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_next_accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    collect(v2, "bp_second");
    @(posedge clk); #1;
    check("bp_second_consumed", 32'(out_valid), 32'd0);

    // Reset during the fifth cycle of a conversion
    wait_ready("rst_mid");
    valor    = 20'h7A5C3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_bcd", {4'h0, bcd_int, bcd_frac}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen  = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rst_mid_no_result", 32'(seen), 32'd0);

    // Random stream with random consumer backpressure
    mon_en = 1'b1;
    fork
      begin
        for (int i = 0; i < N_STREAM; i++) begin
          logic acc;
          int   g;
          valor    = 20'($urandom);
          in_valid = 1'b1;
          acc      = 1'b0;
          g        = 0;
          while (!acc && g < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            g++;
          end
          in_valid = 1'b0;
          if (!acc) check("stream_accept_timeout", 32'd0, 32'd1);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
      begin
        int cyc = 0;
        while (rx_count < N_STREAM && cyc < 20000) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          cyc++;
        end
        out_ready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("stream_count", 32'(rx_count), 32'(N_STREAM));
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
